// File: rtl/mem_req_queue_pkg.sv
// mem_req_queue_pkg
//   Shared constants and helpers for the memory request queue slice.
//   Default widths track the shared memory defines header. Fallback values
//   are supplied only when that header has not been included ahead of this file.

`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 28
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_DATA_CYCLES
`define MEM_DATA_CYCLES 4
`endif

package mem_req_queue_pkg;

  localparam int MEM_ADDR_W  = `MEM_ADDR_BITS;
  localparam int MEM_TAG_W   = `MEM_TAG_BITS;
  localparam int MEM_DATA_W  = `MEM_DATA_BITS;
  localparam int MEM_BEATS   = `MEM_DATA_CYCLES;

  // Width of the in-flight read counter exposed on rd_outstanding.
  localparam int RD_CNT_W = 3;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // FIFO pointer width: index bits plus one wrap bit.
  function automatic int ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_req_queue_if.sv
// mem_req_queue_if
//   One memory port bundle: command channel, write-data channel and
//   read-response channel.
//   master: the requester side (drives commands/data, receives responses).
//   slave : the responder side (drives ready and responses).
//   The queue uses a slave port towards the caches and a master port towards
//   main memory.

interface mem_req_queue_if #(
  parameter int ADDR_BITS = mem_req_queue_pkg::MEM_ADDR_W,
  parameter int TAG_BITS  = mem_req_queue_pkg::MEM_TAG_W,
  parameter int DATA_BITS = mem_req_queue_pkg::MEM_DATA_W
);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_rw;
  logic [ADDR_BITS-1:0]   req_addr;
  logic [TAG_BITS-1:0]    req_tag;

  logic                   data_valid;
  logic                   data_ready;
  logic [DATA_BITS-1:0]   data_bits;
  logic [DATA_BITS/8-1:0] data_mask;

  logic                   resp_valid;
  logic [DATA_BITS-1:0]   resp_data;
  logic [TAG_BITS-1:0]    resp_tag;

  modport master (
    output req_valid, req_rw, req_addr, req_tag,
    output data_valid, data_bits, data_mask,
    input  req_ready, data_ready,
    input  resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_tag,
    input  data_valid, data_bits, data_mask,
    output req_ready, data_ready,
    output resp_valid, resp_data, resp_tag
  );

endinterface

// File: rtl/mem_sync_fifo.sv
// mem_sync_fifo
//   Single-clock in-order FIFO with registered storage and no fall-through:
//   an entry written at edge N is first visible on dout_o after edge N.
//   Ports:
//     clk     - clock, rising edge
//     rst_n   - asynchronous active-low reset (pointers only)
//     push_i  - write din_i (caller guarantees !full_o)
//     din_i   - write payload
//     pop_i   - discard head entry (caller guarantees !empty_o)
//     dout_o  - head entry
//     full_o  - no free slot
//     empty_o - no valid entry

module mem_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  import mem_req_queue_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_bits(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/mem_req_queue.sv
// mem_req_queue
//   Decoupling queue between the cache-side memory port and main memory.
//   Commands and write-data beats are buffered in two independent FIFOs,
//   reads in flight are limited to MAX_RD, and read responses pass straight
//   through to the cache side.
//   Ports:
//     clk            - clock, rising edge
//     reset          - asynchronous active-low reset
//     up_if          - cache-side port (in_req_*, in_data_*, out_resp_*)
//     mem_if         - main-memory port (mem_req_*, mem_req_data_*, mem_resp_*)
//     rd_outstanding - current number of reads in flight

module mem_req_queue #(
  parameter int ADDR_BITS  = mem_req_queue_pkg::MEM_ADDR_W,
  parameter int TAG_BITS   = mem_req_queue_pkg::MEM_TAG_W,
  parameter int DATA_BITS  = mem_req_queue_pkg::MEM_DATA_W,
  parameter int DEPTH      = 4,
  parameter int DATA_BEATS = mem_req_queue_pkg::MEM_BEATS,
  parameter int MAX_RD     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_req_queue_if.slave        up_if,
  mem_req_queue_if.master       mem_if,
  output logic [2:0]            rd_outstanding
);
  import mem_req_queue_pkg::*;

  localparam int CMD_W  = 1 + ADDR_BITS + TAG_BITS;
  localparam int MASK_W = DATA_BITS / 8;
  localparam int DAT_W  = DATA_BITS + MASK_W;
  localparam int BEAT_W = cnt_bits(DATA_BEATS);

  localparam logic [RD_CNT_W-1:0] MAX_RD_C  = RD_CNT_W'(MAX_RD);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(DATA_BEATS - 1);

  logic             cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [CMD_W-1:0] cmd_din, cmd_dout;
  logic             dat_push, dat_pop, dat_full, dat_empty;
  logic [DAT_W-1:0] dat_din, dat_dout;
  logic             head_rw;

  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                last_beat, rd_inc, rd_dec;

  // Command path. Ready looks only at the full flag so the memory-side ready
  // never reaches back into the arbiter combinationally.
  assign up_if.req_ready = ~cmd_full;
  assign cmd_push        = up_if.req_valid & ~cmd_full;
  assign cmd_din         = {up_if.req_rw, up_if.req_addr, up_if.req_tag};

  mem_sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (cmd_push),
    .din_i   (cmd_din),
    .pop_i   (cmd_pop),
    .dout_o  (cmd_dout),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  assign head_rw         = cmd_dout[CMD_W-1];
  assign mem_if.req_rw   = head_rw;
  assign mem_if.req_addr = cmd_dout[TAG_BITS +: ADDR_BITS];
  assign mem_if.req_tag  = cmd_dout[TAG_BITS-1:0];

  // A read at the head waits for a free read slot and blocks everything
  // queued behind it, keeping commands strictly in order.
  assign mem_if.req_valid = ~cmd_empty & (head_rw | (rd_cnt_q < MAX_RD_C));
  assign cmd_pop          = mem_if.req_valid & mem_if.req_ready;

  // Write-data path, independent of the command path.
  assign up_if.data_ready = ~dat_full;
  assign dat_push         = up_if.data_valid & ~dat_full;
  assign dat_din          = {up_if.data_bits, up_if.data_mask};

  mem_sync_fifo #(.WIDTH(DAT_W), .DEPTH(DEPTH)) u_dat_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (dat_push),
    .din_i   (dat_din),
    .pop_i   (dat_pop),
    .dout_o  (dat_dout),
    .full_o  (dat_full),
    .empty_o (dat_empty)
  );

  assign mem_if.data_valid = ~dat_empty;
  assign mem_if.data_bits  = dat_dout[DAT_W-1 -: DATA_BITS];
  assign mem_if.data_mask  = dat_dout[MASK_W-1:0];
  assign dat_pop           = mem_if.data_valid & mem_if.data_ready;

  // Responses are forwarded untouched; there is no backpressure on them.
  assign up_if.resp_valid = mem_if.resp_valid;
  assign up_if.resp_data  = mem_if.resp_data;
  assign up_if.resp_tag   = mem_if.resp_tag;

  // In-flight read accounting. A read completes on its last response beat;
  // responses with nothing outstanding (e.g. after a reset) are not counted.
  assign last_beat = (beat_q == LAST_BEAT);

  always_comb begin
    rd_inc   = cmd_pop & ~head_rw;
    rd_dec   = mem_if.resp_valid & last_beat & (rd_cnt_q != '0);
    rd_cnt_d = rd_cnt_q;
    if (rd_inc && !rd_dec)      rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
    else if (!rd_inc && rd_dec) rd_cnt_d = rd_cnt_q - RD_CNT_W'(1);
    beat_d = beat_q;
    if (mem_if.resp_valid) beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt_q <= '0;
      beat_q   <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      beat_q   <= beat_d;
    end
  end

  assign rd_outstanding = rd_cnt_q;

endmodule

// File: tb/tb_mem_req_queue.sv
module tb_mem_req_queue;

  localparam int AB     = 28;
  localparam int TB_    = 5;
  localparam int DB     = 128;
  localparam int MB     = DB / 8;
  localparam int DEPTH  = 4;
  localparam int BEATS  = 4;
  localparam int MAX_RD = 2;

  typedef struct {
    logic          rw;
    logic [AB-1:0] addr;
    logic [TB_-1:0] tag;
  } cmd_s;

  typedef struct {
    logic [DB-1:0] bits;
    logic [MB-1:0] mask;
  } dat_s;

  logic       clk;
  logic       reset;
  logic [2:0] rd_outstanding;

  mem_req_queue_if #(.ADDR_BITS(AB), .TAG_BITS(TB_), .DATA_BITS(DB)) up_if ();
  mem_req_queue_if #(.ADDR_BITS(AB), .TAG_BITS(TB_), .DATA_BITS(DB)) mem_if ();

  mem_req_queue #(
    .ADDR_BITS(AB), .TAG_BITS(TB_), .DATA_BITS(DB),
    .DEPTH(DEPTH), .DATA_BEATS(BEATS), .MAX_RD(MAX_RD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .up_if          (up_if.slave),
    .mem_if         (mem_if.master),
    .rd_outstanding (rd_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the queue should hold and how many reads are open.
  cmd_s cmd_q[$];
  dat_s dat_q[$];
  int   out_cnt = 0;
  int   beats   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor / scoreboard: sampled at the falling edge, where everything that
  // decides the next rising edge is already stable.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        cmd_q.delete();
        dat_q.delete();
        out_cnt = 0;
        beats   = 0;
        chk("rst_mem_req_valid",  128'(mem_if.req_valid),  128'(0));
        chk("rst_mem_data_valid", 128'(mem_if.data_valid), 128'(0));
        chk("rst_rd_outstanding", 128'(rd_outstanding),    128'(0));
        chk("rst_in_req_ready",   128'(up_if.req_ready),   128'(1));
        chk("rst_in_data_ready",  128'(up_if.data_ready),  128'(1));
      end else begin
        bit exp_cv, exp_dv, cmd_acc, dat_acc;
        int pre;
        chk("resp_valid_fwd", 128'(up_if.resp_valid), 128'(mem_if.resp_valid));
        if (mem_if.resp_valid) begin
          chk("resp_data_fwd", 128'(up_if.resp_data), 128'(mem_if.resp_data));
          chk("resp_tag_fwd",  128'(up_if.resp_tag),  128'(mem_if.resp_tag));
        end
        exp_cv = (cmd_q.size() != 0) && (cmd_q[0].rw || out_cnt < MAX_RD);
        chk("mem_req_valid", 128'(mem_if.req_valid), 128'(exp_cv));
        if (exp_cv && mem_if.req_valid) begin
          chk("mem_req_rw",   128'(mem_if.req_rw),   128'(cmd_q[0].rw));
          chk("mem_req_addr", 128'(mem_if.req_addr), 128'(cmd_q[0].addr));
          chk("mem_req_tag",  128'(mem_if.req_tag),  128'(cmd_q[0].tag));
        end
        chk("in_req_ready", 128'(up_if.req_ready), 128'(cmd_q.size() < DEPTH));
        exp_dv = (dat_q.size() != 0);
        chk("mem_data_valid", 128'(mem_if.data_valid), 128'(exp_dv));
        if (exp_dv && mem_if.data_valid) begin
          chk("mem_data_bits", 128'(mem_if.data_bits), 128'(dat_q[0].bits));
          chk("mem_data_mask", 128'(mem_if.data_mask), 128'(dat_q[0].mask));
        end
        chk("in_data_ready", 128'(up_if.data_ready), 128'(dat_q.size() < DEPTH));
        chk("rd_outstanding", 128'(rd_outstanding), 128'(out_cnt));

        // Effects of the coming rising edge.
        pre     = out_cnt;
        cmd_acc = up_if.req_valid && (cmd_q.size() < DEPTH);
        dat_acc = up_if.data_valid && (dat_q.size() < DEPTH);
        if (exp_cv && mem_if.req_ready) begin
          if (!cmd_q[0].rw) out_cnt++;
          void'(cmd_q.pop_front());
        end
        if (mem_if.resp_valid) begin
          beats++;
          if (beats == BEATS) begin
            beats = 0;
            if (pre > 0) out_cnt--;
          end
        end
        if (cmd_acc) cmd_q.push_back('{up_if.req_rw, up_if.req_addr, up_if.req_tag});
        if (exp_dv && mem_if.data_ready) void'(dat_q.pop_front());
        if (dat_acc) dat_q.push_back('{up_if.data_bits, up_if.data_mask});
      end
    end
  end

  task automatic send_cmd(input logic rw, input logic [AB-1:0] a, input logic [TB_-1:0] t);
    logic acc;
    acc = 1'b0;
    up_if.req_valid = 1'b1;
    up_if.req_rw    = rw;
    up_if.req_addr  = a;
    up_if.req_tag   = t;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = up_if.req_ready;
      tick();
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
    up_if.req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DB-1:0] b, input logic [MB-1:0] m);
    logic acc;
    acc = 1'b0;
    up_if.data_valid = 1'b1;
    up_if.data_bits  = b;
    up_if.data_mask  = m;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = up_if.data_ready;
      tick();
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL data_accept_timeout: got ready=0 expected ready=1 within 200 cycles");
    end
    up_if.data_valid = 1'b0;
  endtask

  task automatic resp_beats(input int n);
    for (int i = 0; i < n; i++) begin
      mem_if.resp_valid = 1'b1;
      mem_if.resp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_if.resp_tag   = TB_'($urandom());
      tick();
    end
    mem_if.resp_valid = 1'b0;
  endtask

  initial begin
    logic [DB-1:0] rd_data;
    reset             = 1'b1;
    up_if.req_valid   = 1'b0;
    up_if.req_rw      = 1'b0;
    up_if.req_addr    = '0;
    up_if.req_tag     = '0;
    up_if.data_valid  = 1'b0;
    up_if.data_bits   = '0;
    up_if.data_mask   = '0;
    mem_if.req_ready  = 1'b1;
    mem_if.data_ready = 1'b1;
    mem_if.resp_valid = 1'b0;
    mem_if.resp_data  = '0;
    mem_if.resp_tag   = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    tick();

    // Basic write path.
    send_cmd(1'b1, 28'h0000100, 5'd3);
    chk("wr_valid", 128'(mem_if.req_valid), 128'(1));
    chk("wr_rw",    128'(mem_if.req_rw),    128'(1));
    chk("wr_tag",   128'(mem_if.req_tag),   128'(3));
    chk("wr_addr",  128'(mem_if.req_addr),  128'(28'h0000100));
    for (int i = 0; i < 4; i++) begin
      send_beat(DB'(128'h1111_0000 + i), 16'hFFFF);
      chk("wr_beat_valid", 128'(mem_if.data_valid), 128'(1));
      chk("wr_beat_bits",  128'(mem_if.data_bits),  128'(128'h1111_0000 + i));
    end
    repeat (3) tick();

    // Fill and backpressure.
    mem_if.req_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_cmd(1'b1, AB'(28'h200 + i), TB_'(i));
    chk("fill_in_req_ready", 128'(up_if.req_ready), 128'(0));
    fork
      send_cmd(1'b1, 28'h0000204, 5'd4);
      begin
        repeat (3) tick();
        chk("fill_held_ready", 128'(up_if.req_ready), 128'(0));
        mem_if.req_ready = 1'b1;
      end
    join
    repeat (8) tick();

    // Read throttling.
    for (int i = 0; i < 3; i++) send_cmd(1'b0, AB'(28'h300 + i), TB_'(8 + i));
    repeat (2) tick();
    chk("thr_valid_blocked", 128'(mem_if.req_valid), 128'(0));
    chk("thr_rd_out_2",      128'(rd_outstanding),   128'(2));
    resp_beats(4);
    chk("thr_rd_out_1",   128'(rd_outstanding),   128'(1));
    chk("thr_third_valid", 128'(mem_if.req_valid), 128'(1));
    tick();
    chk("thr_rd_out_back2", 128'(rd_outstanding), 128'(2));
    resp_beats(4);
    chk("thr_rd_out_after", 128'(rd_outstanding), 128'(1));

    // Read issue coinciding with the last response beat.
    mem_if.req_ready = 1'b0;
    send_cmd(1'b0, 28'h0000400, 5'd12);
    chk("sim_read_valid", 128'(mem_if.req_valid), 128'(1));
    resp_beats(3);
    mem_if.req_ready  = 1'b1;
    mem_if.resp_valid = 1'b1;
    mem_if.resp_data  = '0;
    tick();
    mem_if.resp_valid = 1'b0;
    chk("sim_rd_out_const", 128'(rd_outstanding), 128'(1));

    // Asynchronous reset with work queued.
    send_cmd(1'b0, 28'h0000500, 5'd13);
    tick();
    mem_if.req_ready  = 1'b0;
    mem_if.data_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_cmd(1'b1, AB'(28'h600 + i), TB_'(16 + i));
    for (int i = 0; i < 2; i++) send_beat(DB'(128'hABCD_0000 + i), 16'h00FF);
    chk("rst_pre_rd_out", 128'(rd_outstanding),   128'(2));
    chk("rst_pre_valid",  128'(mem_if.req_valid), 128'(1));
    reset = 1'b0;
    #1;
    chk("async_mem_req_valid", 128'(mem_if.req_valid),  128'(0));
    chk("async_data_valid",    128'(mem_if.data_valid), 128'(0));
    chk("async_rd_out",        128'(rd_outstanding),    128'(0));
    chk("async_in_req_ready",  128'(up_if.req_ready),   128'(1));
    chk("async_in_data_ready", 128'(up_if.data_ready),  128'(1));
    tick();
    tick();
    reset = 1'b0;
    reset = 1'b1;
    tick();
    mem_if.req_ready  = 1'b1;
    mem_if.data_ready = 1'b1;
    chk("post_rst_valid",      128'(mem_if.req_valid),  128'(0));
    chk("post_rst_data_valid", 128'(mem_if.data_valid), 128'(0));
    for (int i = 0; i < 4; i++) begin
      rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_if.resp_valid = 1'b1;
      mem_if.resp_data  = rd_data;
      mem_if.resp_tag   = 5'd21;
      #1;
      chk("stray_fwd_data", 128'(up_if.resp_data),  128'(rd_data));
      chk("stray_fwd_tag",  128'(up_if.resp_tag),   128'(21));
      tick();
    end
    mem_if.resp_valid = 1'b0;
    chk("stray_rd_out_0", 128'(rd_outstanding), 128'(0));

    // Randomized traffic, checked by the monitor each cycle.
    for (int c = 0; c < 2000; c++) begin
      logic r_acc, d_acc;
      @(negedge clk);
      r_acc = up_if.req_valid && up_if.req_ready;
      d_acc = up_if.data_valid && up_if.data_ready;
      tick();
      if (r_acc || !up_if.req_valid) begin
        up_if.req_valid = ($urandom_range(0, 2) != 0);
        up_if.req_rw    = 1'($urandom_range(0, 1));
        up_if.req_addr  = AB'($urandom());
        up_if.req_tag   = TB_'($urandom());
      end
      if (d_acc || !up_if.data_valid) begin
        up_if.data_valid = ($urandom_range(0, 2) != 0);
        up_if.data_bits  = {$urandom(), $urandom(), $urandom(), $urandom()};
        up_if.data_mask  = MB'($urandom());
      end
      mem_if.req_ready  = ($urandom_range(0, 3) != 0);
      mem_if.data_ready = ($urandom_range(0, 3) != 0);
      mem_if.resp_valid = ($urandom_range(0, 3) == 0);
      mem_if.resp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_if.resp_tag   = TB_'($urandom());
    end

    // Drain: no new requests, memory always ready, responses keep flowing.
    up_if.req_valid   = 1'b0;
    up_if.data_valid  = 1'b0;
    mem_if.req_ready  = 1'b1;
    mem_if.data_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      mem_if.resp_valid = ($urandom_range(0, 1) == 0);
      mem_if.resp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    mem_if.resp_valid = 1'b0;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
